// File: rtl/tristate_pkg.sv
// Shared definitions for the tristate schedule driver: FSM encodings and the
// per-line bus resolution rule used by the driver and by bus monitors.
package tristate_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef struct packed {
    logic val;
    logic known;
  } line_res_t;

  // A line is known only when exactly one source drives it; unknown lines read as 0.
  function automatic line_res_t resolve_line(input logic drv, input logic dat,
                                             input logic ext_drv, input logic ext_dat);
    line_res_t res;
    res.known = drv ^ ext_drv;
    res.val   = ((drv & dat) | (ext_drv & ext_dat)) & res.known;
    return res;
  endfunction

endpackage

// File: rtl/tristate_seq_driver_if.sv
// Bundle of table-programming, control, external-driver and observation
// signals for tristate_seq_driver; slave is the driver side.
interface tristate_seq_driver_if #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [WIDTH-1:0]  wr_drive;
  logic [WIDTH-1:0]  wr_data;
  logic [HOLD_W-1:0] wr_hold;
  logic [IDX_W-1:0]  last_idx;
  logic              loop_en;
  logic              start;
  logic              abort;
  logic [WIDTH-1:0]  ext_drive;
  logic [WIDTH-1:0]  ext_d;
  logic [WIDTH-1:0]  drive;
  logic [WIDTH-1:0]  d;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  bus_val;
  logic [WIDTH-1:0]  bus_known;
  logic              contention;
  logic [CNT_W-1:0]  contention_count;

  modport master (
    output wr_en, wr_addr, wr_drive, wr_data, wr_hold, last_idx, loop_en,
           start, abort, ext_drive, ext_d,
    input  drive, d, busy, done, bus_val, bus_known, contention, contention_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_drive, wr_data, wr_hold, last_idx, loop_en,
           start, abort, ext_drive, ext_d,
    output drive, d, busy, done, bus_val, bus_known, contention, contention_count
  );

endinterface

// File: rtl/tristate_resolver.sv
// Combinational resolution of our drive/data against an external driver into
// a two-state value, a known mask and a contention flag.
module tristate_resolver
  import tristate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] drive,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] ext_drive,
  input  logic [WIDTH-1:0] ext_d,
  output logic [WIDTH-1:0] bus_val,
  output logic [WIDTH-1:0] bus_known,
  output logic             contention
);

  line_res_t res;

  always_comb begin
    bus_val   = '0;
    bus_known = '0;
    res       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res          = resolve_line(drive[i], d[i], ext_drive[i], ext_d[i]);
      bus_val[i]   = res.val;
      bus_known[i] = res.known;
    end
  end

  assign contention = |(drive & ext_drive);

endmodule

// File: rtl/tristate_seq_driver.sv
// Table-driven tristate pattern player: steps through programmed drive/data
// entries, each held hold+1 cycles, and tracks bus contention.
module tristate_seq_driver
  import tristate_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  tristate_seq_driver_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0]  drive;
    logic [WIDTH-1:0]  data;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  entry_t            tbl_q [DEPTH];
  entry_t            tbl_d [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  drive_q, drive_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  last_eff;
  logic [IDX_W-1:0]  idx_inc;
  logic              start_ok;
  logic              contention;
  entry_t            cur;
  entry_t            nxt;

  // Out-of-range last_idx only exists for non-power-of-two depths; clamp it.
  always_comb begin
    last_eff = bus.last_idx;
    if ({1'b0, bus.last_idx} > {1'b0, MAX_IDX}) begin
      last_eff = MAX_IDX;
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if (bus.wr_en && (state_q == ST_IDLE) && ({1'b0, bus.wr_addr} <= {1'b0, MAX_IDX})) begin
      tbl_d[bus.wr_addr] = '{drive: bus.wr_drive, data: bus.wr_data, hold: bus.wr_hold};
    end
  end

  assign idx_inc = idx_q + 1'b1;

  // Start loads from tbl_d so a same-cycle write is visible to playback.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    drive_d  = drive_q;
    d_d      = d_q;
    done_d   = (state_q == ST_FINISH);
    start_ok = 1'b0;
    cur      = tbl_q[idx_q];
    nxt      = tbl_q[idx_inc];
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
          idx_d    = '0;
          hold_d   = '0;
          drive_d  = tbl_d[0].drive;
          d_d      = tbl_d[0].data;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_FINISH;
          drive_d = '0;
          d_d     = '0;
        end else if (hold_q < cur.hold) begin
          hold_d = hold_q + 1'b1;
        end else if (idx_q < last_eff) begin
          idx_d   = idx_inc;
          hold_d  = '0;
          drive_d = nxt.drive;
          d_d     = nxt.data;
        end else if (bus.loop_en) begin
          idx_d   = '0;
          hold_d  = '0;
          drive_d = tbl_q[0].drive;
          d_d     = tbl_q[0].data;
        end else begin
          state_d = ST_FINISH;
          drive_d = '0;
          d_d     = '0;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        drive_d = '0;
        d_d     = '0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (start_ok) begin
      count_d = '0;
    end else if (contention && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      drive_q <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      drive_q <= drive_d;
      d_q     <= d_d;
      done_q  <= done_d;
      count_q <= count_d;
      tbl_q   <= tbl_d;
    end
  end

  tristate_resolver #(
    .WIDTH(WIDTH)
  ) u_resolver (
    .drive      (drive_q),
    .d          (d_q),
    .ext_drive  (bus.ext_drive),
    .ext_d      (bus.ext_d),
    .bus_val    (bus.bus_val),
    .bus_known  (bus.bus_known),
    .contention (contention)
  );

  assign bus.drive            = drive_q;
  assign bus.d                = d_q;
  assign bus.busy             = (state_q == ST_RUN);
  assign bus.done             = done_q;
  assign bus.contention       = contention;
  assign bus.contention_count = count_q;

endmodule

// File: tb/tb_tristate_seq_driver.sv
// Directed, table-driven bench for tristate_seq_driver; a second instance
// (DEPTH=6, CNT_W=2) shares the stimulus to cover clamping and saturation.
module tb_tristate_seq_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tristate_seq_driver_if #(.WIDTH(4), .DEPTH(8), .HOLD_W(4), .CNT_W(16)) bus_a ();
  tristate_seq_driver_if #(.WIDTH(4), .DEPTH(6), .HOLD_W(4), .CNT_W(2))  bus_b ();

  tristate_seq_driver #(.WIDTH(4), .DEPTH(8), .HOLD_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  tristate_seq_driver #(.WIDTH(4), .DEPTH(6), .HOLD_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  assign bus_b.wr_en     = bus_a.wr_en;
  assign bus_b.wr_addr   = bus_a.wr_addr;
  assign bus_b.wr_drive  = bus_a.wr_drive;
  assign bus_b.wr_data   = bus_a.wr_data;
  assign bus_b.wr_hold   = bus_a.wr_hold;
  assign bus_b.last_idx  = bus_a.last_idx;
  assign bus_b.loop_en   = bus_a.loop_en;
  assign bus_b.start     = bus_a.start;
  assign bus_b.abort     = bus_a.abort;
  assign bus_b.ext_drive = bus_a.ext_drive;
  assign bus_b.ext_d     = bus_a.ext_d;

  typedef struct {
    string      tag;
    logic       start;
    logic       abort;
    logic [3:0] ext_drive;
    logic [3:0] ext_d;
    logic [3:0] exp_drive;
    logic [3:0] exp_d;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_val;
    logic [3:0] exp_known;
    logic       exp_cont;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input string tag, input logic st, input logic ab,
                                 input logic [3:0] ed, input logic [3:0] edat,
                                 input logic [3:0] xd, input logic [3:0] xdat,
                                 input logic xb, input logic xdn,
                                 input logic [3:0] xv, input logic [3:0] xk, input logic xc);
    vec_t v;
    v.tag = tag; v.start = st; v.abort = ab; v.ext_drive = ed; v.ext_d = edat;
    v.exp_drive = xd; v.exp_d = xdat; v.exp_busy = xb; v.exp_done = xdn;
    v.exp_val = xv; v.exp_known = xk; v.exp_cont = xc;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeEntry(input logic [2:0] addr, input logic [3:0] drv, input logic [3:0] dat,
                            input logic [3:0] hold, input logic with_start);
    bus_a.wr_en    = 1'b1;
    bus_a.wr_addr  = addr;
    bus_a.wr_drive = drv;
    bus_a.wr_data  = dat;
    bus_a.wr_hold  = hold;
    bus_a.start    = with_start;
    step();
    bus_a.wr_en    = 1'b0;
    bus_a.start    = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus_a.start     = v.start;
    bus_a.abort     = v.abort;
    bus_a.ext_drive = v.ext_drive;
    bus_a.ext_d     = v.ext_d;
    step();
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.tag, ".drive"}, 32'(bus_a.drive), 32'(v.exp_drive));
    checkOutput({v.tag, ".d"},     32'(bus_a.d),     32'(v.exp_d));
    checkOutput({v.tag, ".busy"},  32'(bus_a.busy),  32'(v.exp_busy));
    checkOutput({v.tag, ".done"},  32'(bus_a.done),  32'(v.exp_done));
    checkOutput({v.tag, ".val"},   32'(bus_a.bus_val),   32'(v.exp_val));
    checkOutput({v.tag, ".known"}, 32'(bus_a.bus_known), 32'(v.exp_known));
    checkOutput({v.tag, ".cont"},  32'(bus_a.contention), 32'(v.exp_cont));
  endtask

  task automatic runVectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i]);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] loop_exp [5];

    // Legacy two-entry pattern (vectors 0..5)
    addVec("leg0",  1, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("leg1",  0, 0, 4'h0, 4'h0, 4'b0010, 4'b1110, 1, 0, 4'b0010, 4'b0010, 0);
    addVec("leg2",  0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
    addVec("legF",  0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
    addVec("legD",  0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
    addVec("legI",  0, 1, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
    // Hold count 3 (vectors 6..11); start repeated mid-run must be ignored
    addVec("hold0", 1, 0, 4'h0, 4'h0, 4'b1111, 4'b1010, 1, 0, 4'b1010, 4'b1111, 0);
    addVec("hold1", 1, 0, 4'h0, 4'h0, 4'b1111, 4'b1010, 1, 0, 4'b1010, 4'b1111, 0);
    addVec("hold2", 0, 0, 4'h0, 4'h0, 4'b1111, 4'b1010, 1, 0, 4'b1010, 4'b1111, 0);
    addVec("hold3", 0, 0, 4'h0, 4'h0, 4'b1111, 4'b1010, 1, 0, 4'b1010, 4'b1111, 0);
    addVec("holdF", 0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
    addVec("holdD", 0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
    // Contention against external driver (vectors 12..16)
    addVec("con0",  1, 0, 4'b0110, 4'b0100, 4'b0011, 4'b0001, 1, 0, 4'b0101, 4'b0101, 1);
    addVec("con1",  0, 0, 4'b0110, 4'b0100, 4'b0011, 4'b0001, 1, 0, 4'b0101, 4'b0101, 1);
    addVec("con2",  0, 0, 4'b0110, 4'b0100, 4'b0011, 4'b0001, 1, 0, 4'b0101, 4'b0101, 1);
    addVec("conF",  0, 0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 0, 4'b0100, 4'b0110, 0);
    addVec("conD",  0, 0, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 1, 4'b0100, 4'b0110, 0);

    loop_exp = '{4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101};

    bus_a.wr_en = 0; bus_a.wr_addr = '0; bus_a.wr_drive = '0; bus_a.wr_data = '0;
    bus_a.wr_hold = '0; bus_a.last_idx = '0; bus_a.loop_en = 0; bus_a.start = 0;
    bus_a.abort = 0; bus_a.ext_drive = '0; bus_a.ext_d = '0;

    #1;
    checkOutput("rst.drive", 32'(bus_a.drive), 32'h0);
    checkOutput("rst.busy",  32'(bus_a.busy),  32'h0);
    checkOutput("rst.done",  32'(bus_a.done),  32'h0);
    checkOutput("rst.count", 32'(bus_a.contention_count), 32'h0);
    #11;
    rst_n = 1'b1;
    step();

    writeEntry(3'd0, 4'b0000, 4'b0000, 4'd0, 1'b0);
    writeEntry(3'd1, 4'b0010, 4'b1110, 4'd0, 1'b0);
    writeEntry(3'd2, 4'b0000, 4'b0000, 4'd0, 1'b0);
    bus_a.last_idx = 3'd2;
    runVectors(0, 5);
    bus_a.abort = 0;

    writeEntry(3'd0, 4'b1111, 4'b1010, 4'd3, 1'b0);
    bus_a.last_idx = 3'd0;
    runVectors(6, 11);

    writeEntry(3'd0, 4'b0011, 4'b0001, 4'd2, 1'b0);
    runVectors(12, 16);
    checkOutput("con.count", 32'(bus_a.contention_count), 32'd3);
    bus_a.ext_drive = '0;
    bus_a.ext_d     = '0;
    bus_a.start     = 1'b1;
    step();
    bus_a.start     = 1'b0;
    checkOutput("con.clear", 32'(bus_a.contention_count), 32'd0);
    repeat (5) step();

    // Saturation: five contention cycles, 16-bit counter vs 2-bit counter
    writeEntry(3'd0, 4'b0011, 4'b0001, 4'd4, 1'b0);
    bus_a.ext_drive = 4'b0110;
    bus_a.ext_d     = 4'b0100;
    bus_a.start     = 1'b1;
    step();
    bus_a.start     = 1'b0;
    repeat (5) step();
    checkOutput("sat.count16", 32'(bus_a.contention_count), 32'd5);
    checkOutput("sat.count2",  32'(bus_b.contention_count), 32'd3);
    bus_a.ext_drive = '0;
    bus_a.ext_d     = '0;
    repeat (2) step();

    // Loop across the wrap with no gap, then abort
    writeEntry(3'd0, 4'b0101, 4'b0000, 4'd0, 1'b0);
    writeEntry(3'd1, 4'b1010, 4'b1111, 4'd0, 1'b0);
    bus_a.last_idx = 3'd1;
    bus_a.loop_en  = 1'b1;
    bus_a.start    = 1'b1;
    step();
    bus_a.start    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("loop%0d.drive", i), 32'(bus_a.drive), 32'(loop_exp[i]));
      if (i < 4) step();
    end
    bus_a.abort = 1'b1;
    step();
    bus_a.abort = 1'b0;
    checkOutput("abort.drive", 32'(bus_a.drive), 32'h0);
    checkOutput("abort.busy",  32'(bus_a.busy),  32'h0);
    checkOutput("abort.done0", 32'(bus_a.done),  32'h0);
    step();
    checkOutput("abort.done1", 32'(bus_a.done),  32'h1);
    bus_a.loop_en = 1'b0;
    step();

    // Write landing with start, then a write during RUN that must be dropped
    bus_a.last_idx = 3'd0;
    writeEntry(3'd0, 4'b1100, 4'b0110, 4'd1, 1'b1);
    checkOutput("wrst.drive", 32'(bus_a.drive), 32'b1100);
    writeEntry(3'd0, 4'b0011, 4'b0011, 4'd0, 1'b0);
    repeat (3) step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    checkOutput("wrun.drive", 32'(bus_a.drive), 32'b1100);
    checkOutput("wrun.d",     32'(bus_a.d),     32'b0110);
    repeat (3) step();

    // Asynchronous reset in the middle of a long entry
    writeEntry(3'd0, 4'b1111, 4'b0101, 4'd15, 1'b0);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.drive", 32'(bus_a.drive), 32'h0);
    checkOutput("arst.busy",  32'(bus_a.busy),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("arst.nodone0", 32'(bus_a.done), 32'h0);
    step();
    checkOutput("arst.nodone1", 32'(bus_a.done), 32'h0);
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    checkOutput("arst.tbl.busy",  32'(bus_a.busy),  32'h1);
    checkOutput("arst.tbl.drive", 32'(bus_a.drive), 32'h0);
    checkOutput("arst.tbl.d",     32'(bus_a.d),     32'h0);
    repeat (3) step();

    // last_idx beyond DEPTH-1 clamps on the 6-entry instance
    bus_a.last_idx = 3'd7;
    bus_a.start    = 1'b1;
    step();
    bus_a.start    = 1'b0;
    repeat (5) step();
    checkOutput("clamp.busyB5", 32'(bus_b.busy), 32'h1);
    step();
    checkOutput("clamp.busyB6", 32'(bus_b.busy), 32'h0);
    checkOutput("clamp.busyA6", 32'(bus_a.busy), 32'h1);
    step();
    checkOutput("clamp.doneB",  32'(bus_b.done), 32'h1);
    repeat (4) step();
    checkOutput("clamp.idleA",  32'(bus_a.busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
